// File: rtl/term_acc_pkg.sv
// Shared types and default widths for the term accumulator and its adder slice.
package term_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int TERM_SIZE_DEF = 9;
  localparam int NUM_TERMS_DEF = 4;
  localparam int ACC_WIDTH_DEF = 16;
  localparam int COUNT_W       = 8;

endpackage

// File: rtl/term_acc_addsat.sv
// Combinational accumulator + term add with carry detect; saturates instead of
// wrapping when TERM_ACC_SATURATE_EN is defined.
module term_acc_addsat
  import term_acc_pkg::*;
#(
  parameter int TERM_SIZE = TERM_SIZE_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [TERM_SIZE-1:0] term,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);

  logic [ACC_WIDTH:0] full;

  assign full  = {1'b0, acc} + {{(ACC_WIDTH + 1 - TERM_SIZE){1'b0}}, term};
  assign carry = full[ACC_WIDTH];

`ifdef TERM_ACC_SATURATE_EN
  // Once clamped at all-ones, any nonzero term carries again, so it stays clamped.
  assign sum = carry ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
  assign sum = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/term_accumulator.sv
// Sums groups of NUM_TERMS unsigned terms; sum valid the cycle after the last accept,
// held in DONE until Sum_Ready (no terms taken in DONE). Optional TERM_ACC_SATURATE_EN.
module term_accumulator
  import term_acc_pkg::*;
#(
  parameter int TERM_SIZE = TERM_SIZE_DEF,
  parameter int NUM_TERMS = NUM_TERMS_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Clear,
  input  logic [TERM_SIZE-1:0] In_Term,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [ACC_WIDTH-1:0] Sum_Out,
  output logic                 Sum_Valid,
  input  logic                 Sum_Ready,
  output logic [COUNT_W-1:0]   Term_Count,
  output logic                 Overflow
);

  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(NUM_TERMS);

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [ACC_WIDTH-1:0] sum_q, sum_nxt;
  logic [ACC_WIDTH-1:0] add_sum;
  logic [COUNT_W-1:0]   cnt, cnt_nxt;
  logic                 ovf, ovf_nxt;
  logic                 add_carry;
  logic                 accept;

  term_acc_addsat #(
    .TERM_SIZE(TERM_SIZE),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_addsat (
    .acc  (acc),
    .term (In_Term),
    .sum  (add_sum),
    .carry(add_carry)
  );

  assign In_Ready   = (state != DONE);
  assign Sum_Valid  = (state == DONE);
  assign Sum_Out    = sum_q;
  assign Term_Count = cnt;
  assign Overflow   = ovf;
  assign accept     = In_Valid && (state != DONE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sum_nxt   = sum_q;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (Clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      sum_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt = ACC_WIDTH'(In_Term);
            cnt_nxt = CNT_ONE;
            ovf_nxt = 1'b0;
            if (NUM_TERMS == 1) begin
              state_nxt = DONE;
              sum_nxt   = ACC_WIDTH'(In_Term);
            end else begin
              state_nxt = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = add_sum;
            cnt_nxt = cnt + CNT_ONE;
            ovf_nxt = ovf | add_carry;
            if (cnt + CNT_ONE == CNT_LAST) begin
              state_nxt = DONE;
              sum_nxt   = add_sum;
            end
          end
        end
        DONE: begin
          // Sum_Out keeps the last group's value after the handshake.
          if (Sum_Ready) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc   <= '0;
      sum_q <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      sum_q <= sum_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_term_accumulator.sv
// Directed bench: default instance with a sum scoreboard, plus a narrow-accumulator
// instance (overflow/saturation) and a single-term-group instance.
module tb_term_accumulator;
  import term_acc_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  // default instance
  logic        clear0, in_valid0, sum_ready0;
  logic [8:0]  in_term0;
  logic        in_ready0, sum_valid0, overflow0;
  logic [15:0] sum_out0;
  logic [7:0]  term_count0;

  // ACC_WIDTH = 10 instance
  logic        clear1, in_valid1, sum_ready1;
  logic [8:0]  in_term1;
  logic        in_ready1, sum_valid1, overflow1;
  logic [9:0]  sum_out1;
  logic [7:0]  term_count1;

  // NUM_TERMS = 1 instance
  logic        clear2, in_valid2, sum_ready2;
  logic [8:0]  in_term2;
  logic        in_ready2, sum_valid2, overflow2;
  logic [15:0] sum_out2;
  logic [7:0]  term_count2;

`ifdef TERM_ACC_SATURATE_EN
  localparam int EXP_OVF_SUM = 1023;
`else
  localparam int EXP_OVF_SUM = 1020;
`endif

  term_accumulator u0 (
    .CLK(CLK), .RST_N(RST_N), .Clear(clear0), .In_Term(in_term0), .In_Valid(in_valid0),
    .In_Ready(in_ready0), .Sum_Out(sum_out0), .Sum_Valid(sum_valid0), .Sum_Ready(sum_ready0),
    .Term_Count(term_count0), .Overflow(overflow0)
  );

  term_accumulator #(.TERM_SIZE(9), .NUM_TERMS(4), .ACC_WIDTH(10)) u1 (
    .CLK(CLK), .RST_N(RST_N), .Clear(clear1), .In_Term(in_term1), .In_Valid(in_valid1),
    .In_Ready(in_ready1), .Sum_Out(sum_out1), .Sum_Valid(sum_valid1), .Sum_Ready(sum_ready1),
    .Term_Count(term_count1), .Overflow(overflow1)
  );

  term_accumulator #(.TERM_SIZE(9), .NUM_TERMS(1), .ACC_WIDTH(16)) u2 (
    .CLK(CLK), .RST_N(RST_N), .Clear(clear2), .In_Term(in_term2), .In_Valid(in_valid2),
    .In_Ready(in_ready2), .Sum_Out(sum_out2), .Sum_Valid(sum_valid2), .Sum_Ready(sum_ready2),
    .Term_Count(term_count2), .Overflow(overflow2)
  );

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one term per cycle into u0; the expected sum is queued with the last term.
  task automatic send4(input int a, input int b, input int c, input int d);
    int t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1;
      in_term0  = 9'(t[i]);
      if (i == 3) exp_q.push_back(a + b + c + d);
      tick();
    end
    in_valid0 = 1'b0;
  endtask

  task automatic check_sum(input string tag);
    int e;
    chk({tag, "_valid"}, 32'(sum_valid0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk({tag, "_sum"}, 32'(sum_out0), e);
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready0), 1);
    chk({tag, "_sum_valid"}, 32'(sum_valid0), 0);
    chk({tag, "_sum_out"}, 32'(sum_out0), 0);
    chk({tag, "_count"}, 32'(term_count0), 0);
    chk({tag, "_ovf"}, 32'(overflow0), 0);
  endtask

  initial begin
    RST_N = 1'b0;
    clear0 = 0; in_valid0 = 0; in_term0 = '0; sum_ready0 = 0;
    clear1 = 0; in_valid1 = 0; in_term1 = '0; sum_ready1 = 0;
    clear2 = 0; in_valid2 = 0; in_term2 = '0; sum_ready2 = 0;
    tick();
    tick();
    check_reset0("reset");
    RST_N = 1'b1;

    // basic group, consumer always ready
    sum_ready0 = 1'b1;
    send4(1, 2, 3, 4);
    check_sum("basic");
    chk("basic_count", 32'(term_count0), 4);
    chk("basic_in_ready", 32'(in_ready0), 0);
    tick();
    chk("basic_valid_drop", 32'(sum_valid0), 0);
    chk("basic_sum_hold", 32'(sum_out0), 10);
    chk("basic_count_clr", 32'(term_count0), 0);

    // gaps between terms and held back-pressure
    sum_ready0 = 1'b0;
    in_valid0 = 1; in_term0 = 9'd100; tick();
    in_valid0 = 0; tick(); tick();
    in_valid0 = 1; in_term0 = 9'd0; tick();
    in_valid0 = 0; tick();
    in_valid0 = 1; in_term0 = 9'd511; tick();
    in_valid0 = 0; tick(); tick();
    chk("gap_count", 32'(term_count0), 3);
    chk("gap_valid_early", 32'(sum_valid0), 0);
    in_valid0 = 1; in_term0 = 9'd7; exp_q.push_back(618); tick();
    in_term0 = 9'd55;
    check_sum("gap");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sum", 32'(sum_out0), 618);
      chk("bp_in_ready", 32'(in_ready0), 0);
      chk("bp_count", 32'(term_count0), 4);
    end
    sum_ready0 = 1'b1;
    tick();
    chk("release_valid", 32'(sum_valid0), 0);
    chk("release_in_ready", 32'(in_ready0), 1);
    chk("release_no_accept", 32'(term_count0), 0);
    in_valid0 = 1'b0;
    tick();

    // max terms, no overflow at 16 bits
    send4(511, 511, 511, 511);
    check_sum("max");
    chk("max_ovf", 32'(overflow0), 0);
    tick();

    // clear mid-group drops the concurrent term
    in_valid0 = 1; in_term0 = 9'd5; tick();
    in_term0 = 9'd6; tick();
    chk("pre_clear_count", 32'(term_count0), 2);
    clear0 = 1'b1; in_term0 = 9'd9; tick();
    clear0 = 1'b0; in_valid0 = 1'b0;
    chk("clear_count", 32'(term_count0), 0);
    chk("clear_sum", 32'(sum_out0), 0);
    chk("clear_in_ready", 32'(in_ready0), 1);
    send4(1, 1, 1, 1);
    check_sum("post_clear");
    chk("post_clear_count", 32'(term_count0), 4);
    tick();

    // reset mid-group, then reset while holding a sum in DONE
    in_valid0 = 1; in_term0 = 9'd3; tick(); tick();
    in_valid0 = 0;
    RST_N = 1'b0; tick();
    check_reset0("rst_mid");
    RST_N = 1'b1;
    sum_ready0 = 1'b0;
    send4(2, 2, 2, 2);
    check_sum("pre_rst_done");
    RST_N = 1'b0; tick();
    check_reset0("rst_done");
    RST_N = 1'b1;
    sum_ready0 = 1'b1;
    send4(1, 2, 3, 4);
    check_sum("after_rst");
    tick();

    // 10-bit accumulator overflow (wrap or clamp depending on build)
    sum_ready1 = 1'b0;
    in_valid1 = 1'b1; in_term1 = 9'd511;
    tick(); tick();
    chk("w10_no_ovf_yet", 32'(overflow1), 0);
    tick();
    chk("w10_ovf_sticky", 32'(overflow1), 1);
    tick();
    in_valid1 = 1'b0;
    chk("w10_valid", 32'(sum_valid1), 1);
    chk("w10_sum", 32'(sum_out1), EXP_OVF_SUM);
    chk("w10_ovf", 32'(overflow1), 1);
    chk("w10_count", 32'(term_count1), 4);
    chk("w10_in_ready", 32'(in_ready1), 0);
    sum_ready1 = 1'b1;
    tick();
    chk("w10_ovf_clr", 32'(overflow1), 0);
    chk("w10_valid_drop", 32'(sum_valid1), 0);

    // single-term groups
    sum_ready2 = 1'b1;
    in_valid2 = 1'b1; in_term2 = 9'd42;
    tick();
    in_valid2 = 1'b0;
    chk("n1_valid", 32'(sum_valid2), 1);
    chk("n1_sum", 32'(sum_out2), 42);
    chk("n1_count", 32'(term_count2), 1);
    chk("n1_ovf", 32'(overflow2), 0);
    tick();
    chk("n1_valid_drop", 32'(sum_valid2), 0);
    chk("n1_in_ready", 32'(in_ready2), 1);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
